// File: rtl/tile_row_fetcher.sv
// rtl/tile_row_fetcher.sv - background/window tile row fetcher for the pixel pipeline
module tile_row_fetcher #(
  parameter int          PLANES    = 2,
  parameter int          MAP_W     = 32,
  parameter int          X_MAX     = 160,
  parameter int          Y_MAX     = 154,
  parameter logic [15:0] MAP0_BASE = 16'h9800,
  parameter logic [15:0] MAP1_BASE = 16'h9C00
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      tclk_in,
  input  logic                      fetch_ena_in,
  input  logic                      frame_start_in,
  input  logic [$clog2(X_MAX)-1:0]  x_in,
  input  logic [$clog2(Y_MAX)-1:0]  y_in,
  input  logic [7:0]                scx_in,
  input  logic [7:0]                scy_in,
  input  logic [7:0]                wx_in,
  input  logic                      wy_cond_in,
  input  logic                      win_ena_in,
  input  logic                      bg_map_in,
  input  logic                      win_map_in,
  input  logic                      addr_mode_in,
  output logic [15:0]               addr_out,
  output logic                      addr_valid_out,
  input  logic [7:0]                data_in,
  input  logic                      data_valid_in,
  input  logic                      fifo_empty_in,
  output logic                      pixels_valid_out,
  output logic [8*PLANES-1:0]       pixels_out,
  output logic                      window_active_out,
  output logic [7:0]                win_line_out
);

  localparam int MB = $clog2(MAP_W);
  localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PLANES - 1);

  typedef enum logic [2:0] {IDLE, MAP_REQ, MAP_WAIT, PLANE_REQ, PLANE_WAIT, PUSH} state_t;

  state_t              state, next_state;
  logic [MB-1:0]       fetch_x, win_x, xcoord;
  logic [7:0]          tile_num, ycoord, win_line;
  logic [7:0]          planes [PLANES];
  logic [PW-1:0]       p;
  logic                window_active, fetch_ena_q, win_hit, trigger;
  logic [15:0]         map_base, map_addr, tile_ext, tile_base, plane_addr;
  logic [8*PLANES-1:0] packed_pix;

  assign window_active_out = window_active;
  assign win_line_out      = win_line;

  // Window start test, done in 9 bits so x+7 cannot wrap past wx.
  assign win_hit = win_ena_in && wy_cond_in && !window_active &&
                   ((9'(x_in) + 9'd7) >= {1'b0, wx_in});

  // Tile-map, tile-data addresses and the packed pixel row.
  always_comb begin
    ycoord     = window_active ? win_line : (scy_in + 8'(y_in));
    xcoord     = window_active ? win_x : (MB'(scx_in >> 3) + fetch_x);
    map_base   = (window_active ? win_map_in : bg_map_in) ? MAP1_BASE : MAP0_BASE;
    map_addr   = map_base + 16'(ycoord >> 3) * 16'(MAP_W) + 16'(xcoord);
    tile_ext   = addr_mode_in ? {8'h00, tile_num} : {{8{tile_num[7]}}, tile_num};
    tile_base  = (addr_mode_in ? 16'h8000 : 16'h9000) + tile_ext * 16'(8 * PLANES);
    plane_addr = tile_base + 16'(ycoord[2:0]) * 16'(PLANES) + 16'(p);
    packed_pix = '0;
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < PLANES; k++)
        packed_pix[i*PLANES+k] = planes[k][7-i];
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else            state <= next_state;
  end

  // Next state; a window start overrides whatever the fetch was doing.
  always_comb begin
    next_state = state;
    trigger    = 1'b0;
    if (!fetch_ena_in) begin
      next_state = IDLE;
    end else if (tclk_in) begin
      if (state != IDLE && win_hit) begin
        trigger    = 1'b1;
        next_state = MAP_REQ;
      end else begin
        case (state)
          IDLE:       next_state = MAP_REQ;
          MAP_REQ:    next_state = MAP_WAIT;
          MAP_WAIT:   if (data_valid_in) next_state = PLANE_REQ;
          PLANE_REQ:  next_state = PLANE_WAIT;
          PLANE_WAIT: if (data_valid_in) next_state = (p == P_LAST) ? PUSH : PLANE_REQ;
          PUSH:       if (fifo_empty_in) next_state = MAP_REQ;
          default:    next_state = IDLE;
        endcase
      end
    end
  end

  // Datapath: request bus, latches, counters and push strobe.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      addr_out         <= '0;
      addr_valid_out   <= 1'b0;
      pixels_valid_out <= 1'b0;
      pixels_out       <= '0;
      fetch_x          <= '0;
      win_x            <= '0;
      tile_num         <= '0;
      p                <= '0;
      window_active    <= 1'b0;
      fetch_ena_q      <= 1'b0;
      win_line         <= '0;
      for (int k = 0; k < PLANES; k++) planes[k] <= '0;
    end else begin
      pixels_valid_out <= 1'b0;
      fetch_ena_q      <= fetch_ena_in;
      if (frame_start_in)
        win_line <= '0;
      else if (fetch_ena_q && !fetch_ena_in && window_active)
        win_line <= win_line + 8'd1;

      if (!fetch_ena_in) begin
        addr_valid_out <= 1'b0;
      end else if (tclk_in) begin
        if (trigger) begin
          window_active  <= 1'b1;
          win_x          <= '0;
          addr_valid_out <= 1'b0;
        end else begin
          case (state)
            IDLE: begin
              fetch_x       <= '0;
              win_x         <= '0;
              window_active <= 1'b0;
            end
            MAP_REQ: begin
              addr_out       <= map_addr;
              addr_valid_out <= 1'b1;
            end
            MAP_WAIT: if (data_valid_in) begin
              tile_num       <= data_in;
              addr_valid_out <= 1'b0;
              p              <= '0;
            end
            PLANE_REQ: begin
              addr_out       <= plane_addr;
              addr_valid_out <= 1'b1;
            end
            PLANE_WAIT: if (data_valid_in) begin
              planes[p]      <= data_in;
              addr_valid_out <= 1'b0;
              if (p != P_LAST) p <= p + PW'(1);
            end
            PUSH: if (fifo_empty_in) begin
              pixels_valid_out <= 1'b1;
              pixels_out       <= packed_pix;
              if (window_active) win_x   <= win_x + MB'(1);
              else               fetch_x <= fetch_x + MB'(1);
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_tile_row_fetcher.sv
// tb/tb_tile_row_fetcher.sv - scoreboard bench for tile_row_fetcher
module tb_tile_row_fetcher;

  logic        clk_in = 0, rst_n_in = 0, tclk_in = 0;
  logic        fetch_ena_in = 0, frame_start_in = 0;
  logic [7:0]  x_in = 0, y_in = 0, scx_in = 0, scy_in = 0, wx_in = 0;
  logic        wy_cond_in = 0, win_ena_in = 0, bg_map_in = 0, win_map_in = 0, addr_mode_in = 1;
  logic [15:0] addr_out;
  logic        addr_valid_out;
  logic [7:0]  data_in = 0;
  logic        data_valid_in = 0, fifo_empty_in = 1;
  logic        pixels_valid_out, window_active_out;
  logic [15:0] pixels_out;
  logic [7:0]  win_line_out;

  logic        fetch_ena4 = 0, valid4, dv4 = 0, pv4, wa4;
  logic [15:0] addr4;
  logic [7:0]  data4 = 0, wl4;
  logic [31:0] pix4;

  tile_row_fetcher #(.PLANES(2)) u_dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .tclk_in(tclk_in), .fetch_ena_in(fetch_ena_in),
    .frame_start_in(frame_start_in), .x_in(x_in), .y_in(y_in), .scx_in(scx_in), .scy_in(scy_in),
    .wx_in(wx_in), .wy_cond_in(wy_cond_in), .win_ena_in(win_ena_in), .bg_map_in(bg_map_in),
    .win_map_in(win_map_in), .addr_mode_in(addr_mode_in), .addr_out(addr_out),
    .addr_valid_out(addr_valid_out), .data_in(data_in), .data_valid_in(data_valid_in),
    .fifo_empty_in(fifo_empty_in), .pixels_valid_out(pixels_valid_out), .pixels_out(pixels_out),
    .window_active_out(window_active_out), .win_line_out(win_line_out));

  tile_row_fetcher #(.PLANES(4)) u_dut4 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .tclk_in(tclk_in), .fetch_ena_in(fetch_ena4),
    .frame_start_in(frame_start_in), .x_in(x_in), .y_in(y_in), .scx_in(scx_in), .scy_in(scy_in),
    .wx_in(wx_in), .wy_cond_in(wy_cond_in), .win_ena_in(1'b0), .bg_map_in(bg_map_in),
    .win_map_in(win_map_in), .addr_mode_in(addr_mode_in), .addr_out(addr4),
    .addr_valid_out(valid4), .data_in(data4), .data_valid_in(dv4),
    .fifo_empty_in(1'b1), .pixels_valid_out(pv4), .pixels_out(pix4),
    .window_active_out(wa4), .win_line_out(wl4));

  int          ncomp = 0, nfail = 0;
  int          push_count = 0, tclk_count = 0, last_push_tclk = 0, prev_push_tclk = 0;
  int          delay_left = 0;
  logic [15:0] stall_addr = 16'hFFFF;
  logic [7:0]  mem [0:65535];
  logic [15:0] exp_addr [$];
  logic [15:0] exp_pix [$];
  logic        prev_v = 0;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) #1 tclk_in = ~tclk_in;

  function automatic logic [31:0] pack(input int np, input logic [7:0] b0, b1, b2, b3);
    logic [7:0]  pl [4];
    logic [31:0] r;
    pl[0] = b0; pl[1] = b1; pl[2] = b2; pl[3] = b3;
    r = '0;
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < np; k++)
        r[i*np+k] = pl[k][7-i];
    return r;
  endfunction

  // Memory model: garbage valid on non-tclk cycles, optional wait states, stall address.
  always @(negedge clk_in) begin
    if (!tclk_in) begin
      data_valid_in = 1'b1; data_in = 8'hEE;
    end else if (addr_valid_out && addr_out != stall_addr) begin
      if (delay_left > 0) begin
        delay_left--; data_valid_in = 1'b0;
      end else begin
        data_valid_in = 1'b1; data_in = mem[addr_out];
      end
    end else begin
      data_valid_in = 1'b0; data_in = 8'h00;
    end
    dv4   = valid4 && tclk_in;
    data4 = mem[addr4];
  end

  // Scoreboard monitor for the PLANES=2 instance.
  always @(negedge clk_in) begin
    logic [15:0] e;
    if (tclk_in) tclk_count++;
    if (addr_valid_out && !prev_v && exp_addr.size() > 0) begin
      e = exp_addr.pop_front();
      ncomp++;
      if (addr_out !== e) begin
        nfail++; $display("FAIL req_addr got=%h want=%h", addr_out, e);
      end
    end
    prev_v = addr_valid_out;
    if (pixels_valid_out) begin
      push_count++;
      prev_push_tclk = last_push_tclk;
      last_push_tclk = tclk_count;
      if (exp_pix.size() > 0) begin
        e = exp_pix.pop_front();
        ncomp++;
        if (pixels_out !== e) begin
          nfail++; $display("FAIL push_pixels got=%h want=%h", pixels_out, e);
        end
      end
    end
  end

  task automatic stop_fetch();
    @(negedge clk_in) fetch_ena_in = 0;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic check_queues(input string name);
    ncomp++;
    if (exp_addr.size() != 0 || exp_pix.size() != 0) begin
      nfail++;
      $display("FAIL %s_queues left_addr=%0d left_pix=%0d want=0", name, exp_addr.size(), exp_pix.size());
    end
  endtask

  task automatic wait_pushes(input string name, input int target);
    for (int i = 0; i < 600 && push_count < target; i++) @(negedge clk_in);
    ncomp++;
    if (push_count < target) begin
      nfail++; $display("FAIL %s_timeout pushes=%0d want=%0d", name, push_count, target);
    end
  endtask

  task automatic test_reset();
    rst_n_in = 0;
    repeat (3) @(negedge clk_in);
    ncomp += 6;
    if (addr_out !== 16'h0)       begin nfail++; $display("FAIL rst_addr got=%h want=0", addr_out); end
    if (addr_valid_out !== 1'b0)  begin nfail++; $display("FAIL rst_valid got=%b want=0", addr_valid_out); end
    if (pixels_valid_out !== 1'b0) begin nfail++; $display("FAIL rst_pv got=%b want=0", pixels_valid_out); end
    if (pixels_out !== 16'h0)     begin nfail++; $display("FAIL rst_pix got=%h want=0", pixels_out); end
    if (window_active_out !== 1'b0) begin nfail++; $display("FAIL rst_wa got=%b want=0", window_active_out); end
    if (win_line_out !== 8'h0)    begin nfail++; $display("FAIL rst_wl got=%h want=0", win_line_out); end
    rst_n_in = 1;
    repeat (4) @(negedge clk_in);
    ncomp++;
    if (addr_valid_out !== 1'b0) begin nfail++; $display("FAIL idle_valid got=%b want=0", addr_valid_out); end
  endtask

  task automatic test_basic();
    logic [31:0] t;
    int pc = push_count;
    addr_mode_in = 1; scx_in = 0; scy_in = 0; y_in = 0; fifo_empty_in = 1;
    exp_addr = '{16'h9800, 16'h8010, 16'h8011, 16'h9801, 16'h8020, 16'h8021};
    exp_pix.push_back(16'h0A5F);
    t = pack(2, 8'h81, 8'h3C, 8'h00, 8'h00);
    exp_pix.push_back(t[15:0]);
    @(negedge clk_in) fetch_ena_in = 1;
    wait_pushes("basic", pc + 2);
    ncomp++;
    if (last_push_tclk - prev_push_tclk != 7) begin
      nfail++; $display("FAIL tile_period got=%0d want=7", last_push_tclk - prev_push_tclk);
    end
    repeat (4) @(negedge clk_in);
    ncomp++;
    if (pixels_out !== 16'h4AA1) begin nfail++; $display("FAIL pix_stable got=%h want=4aa1", pixels_out); end
    check_queues("basic");
    stop_fetch();
  endtask

  task automatic test_signed_wrap();
    logic [31:0] t;
    int pc = push_count;
    addr_mode_in = 0; scx_in = 8'hF8; scy_in = 8'd3; y_in = 0;
    exp_addr = '{16'h981F, 16'h8806, 16'h8807, 16'h9800, 16'h9016, 16'h9017};
    t = pack(2, 8'h55, 8'h0F, 8'h00, 8'h00); exp_pix.push_back(t[15:0]);
    t = pack(2, 8'hA0, 8'h11, 8'h00, 8'h00); exp_pix.push_back(t[15:0]);
    @(negedge clk_in) fetch_ena_in = 1;
    wait_pushes("signed", pc + 2);
    check_queues("signed");
    stop_fetch();
  endtask

  task automatic test_stall();
    int pc = push_count;
    addr_mode_in = 1; scx_in = 0; scy_in = 0; y_in = 0; fifo_empty_in = 0; delay_left = 3;
    exp_addr = '{16'h9800, 16'h8010, 16'h8011};
    exp_pix.push_back(16'h0A5F);
    @(negedge clk_in) fetch_ena_in = 1;
    for (int i = 0; i < 50 && !addr_valid_out; i++) @(negedge clk_in);
    for (int k = 0; k < 3; k++) begin
      repeat (2) @(negedge clk_in);
      ncomp++;
      if (addr_valid_out !== 1'b1 || addr_out !== 16'h9800) begin
        nfail++; $display("FAIL map_hold%0d got=%b/%h want=1/9800", k, addr_valid_out, addr_out);
      end
    end
    repeat (40) @(negedge clk_in);
    ncomp++;
    if (push_count != pc) begin nfail++; $display("FAIL fifo_full_push got=%0d want=%0d", push_count, pc); end
    fifo_empty_in = 1;
    wait_pushes("stall", pc + 1);
    check_queues("stall");
    stop_fetch();
  endtask

  task automatic test_window();
    logic [31:0] t;
    int pc;
    addr_mode_in = 1; scx_in = 0; scy_in = 0; y_in = 0; x_in = 0;
    win_map_in = 1; wx_in = 8'd7; wy_cond_in = 1; win_ena_in = 0; stall_addr = 16'h8010;
    exp_addr = '{16'h9800, 16'h8010, 16'h9C00, 16'h8020, 16'h8021, 16'h9C01};
    t = pack(2, 8'h81, 8'h3C, 8'h00, 8'h00); exp_pix.push_back(t[15:0]);
    @(negedge clk_in) fetch_ena_in = 1;
    for (int i = 0; i < 100 && !(addr_valid_out && addr_out == 16'h8010); i++) @(negedge clk_in);
    pc = push_count;
    win_ena_in = 1;
    for (int i = 0; i < 20 && !window_active_out; i++) @(negedge clk_in);
    stall_addr = 16'hFFFF;
    ncomp++;
    if (window_active_out !== 1'b1) begin nfail++; $display("FAIL win_active got=%b want=1", window_active_out); end
    wait_pushes("window", pc + 1);
    ncomp++;
    if (push_count != pc + 1) begin nfail++; $display("FAIL win_abort_push got=%0d want=%0d", push_count - pc, 1); end
    for (int i = 0; i < 100 && exp_addr.size() > 0; i++) @(negedge clk_in);
    check_queues("window");
    stop_fetch();
    ncomp += 2;
    if (win_line_out !== 8'd1) begin nfail++; $display("FAIL win_line_inc got=%0d want=1", win_line_out); end
    if (window_active_out !== 1'b1) begin nfail++; $display("FAIL win_active_hold got=%b want=1", window_active_out); end
    @(negedge clk_in) fetch_ena_in = 1;
    repeat (10) @(negedge clk_in);
    ncomp++;
    if (window_active_out !== 1'b1) begin nfail++; $display("FAIL win_retrig got=%b want=1", window_active_out); end
    fetch_ena_in = 0; frame_start_in = 1;
    @(negedge clk_in) frame_start_in = 0;
    repeat (2) @(negedge clk_in);
    ncomp++;
    if (win_line_out !== 8'd0) begin nfail++; $display("FAIL frame_start_wins got=%0d want=0", win_line_out); end
    win_ena_in = 0; win_map_in = 0;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic test_reset_mid();
    addr_mode_in = 1; scx_in = 0; scy_in = 0; y_in = 0; stall_addr = 16'h8010;
    exp_addr = '{16'h9800, 16'h8010};
    @(negedge clk_in) fetch_ena_in = 1;
    for (int i = 0; i < 100 && !(addr_valid_out && addr_out == 16'h8010); i++) @(negedge clk_in);
    #2 rst_n_in = 0;
    #1;
    ncomp += 4;
    if (addr_out !== 16'h0)      begin nfail++; $display("FAIL arst_addr got=%h want=0", addr_out); end
    if (addr_valid_out !== 1'b0) begin nfail++; $display("FAIL arst_valid got=%b want=0", addr_valid_out); end
    if (pixels_out !== 16'h0)    begin nfail++; $display("FAIL arst_pix got=%h want=0", pixels_out); end
    if (window_active_out !== 1'b0) begin nfail++; $display("FAIL arst_wa got=%b want=0", window_active_out); end
    stall_addr = 16'hFFFF;
    exp_addr = '{16'h9800};
    @(negedge clk_in) rst_n_in = 1;
    for (int i = 0; i < 50 && exp_addr.size() > 0; i++) @(negedge clk_in);
    check_queues("reset_mid");
    stop_fetch();
  endtask

  task automatic test_planes4();
    logic [15:0] exp4 [5];
    logic [31:0] want;
    int k = 0, pushes = 0, t0 = 0;
    logic pv = 0;
    exp4 = '{16'h9800, 16'h8028, 16'h8029, 16'h802A, 16'h802B};
    want = pack(4, 8'hFF, 8'h0F, 8'h33, 8'h55);
    addr_mode_in = 1; scx_in = 0; scy_in = 0; y_in = 8'd2;
    @(negedge clk_in) fetch_ena4 = 1;
    for (int i = 0; i < 600 && pushes < 2; i++) begin
      @(negedge clk_in);
      if (valid4 && !pv && k < 5) begin
        ncomp++;
        if (addr4 !== exp4[k]) begin nfail++; $display("FAIL p4_addr%0d got=%h want=%h", k, addr4, exp4[k]); end
        k++;
      end
      pv = valid4;
      if (pv4) begin
        pushes++;
        ncomp++;
        if (pushes == 1) begin
          t0 = tclk_count;
          if (pix4 !== want) begin nfail++; $display("FAIL p4_pixels got=%h want=%h", pix4, want); end
        end else if (tclk_count - t0 != 11) begin
          nfail++; $display("FAIL p4_period got=%0d want=11", tclk_count - t0);
        end
      end
    end
    ncomp++;
    if (pushes != 2 || k != 5) begin nfail++; $display("FAIL p4_progress pushes=%0d reqs=%0d want=2/5", pushes, k); end
    @(negedge clk_in) fetch_ena4 = 0;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h9800] = 8'h01; mem[16'h8010] = 8'hF0; mem[16'h8011] = 8'hCC;
    mem[16'h9801] = 8'h02; mem[16'h8020] = 8'h81; mem[16'h8021] = 8'h3C;
    mem[16'h981F] = 8'h80; mem[16'h8806] = 8'h55; mem[16'h8807] = 8'h0F;
    mem[16'h9016] = 8'hA0; mem[16'h9017] = 8'h11; mem[16'h9C00] = 8'h02;
    mem[16'h8028] = 8'hFF; mem[16'h8029] = 8'h0F; mem[16'h802A] = 8'h33; mem[16'h802B] = 8'h55;
    test_reset();
    test_basic();
    test_signed_wrap();
    test_stall();
    test_window();
    test_reset_mid();
    test_planes4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
